quadra_ctrl: RTL

- Streaming sequencer around the quadra datapath; evaluates the piecewise-quadratic approximation y = a + b*x2 + c*x2^2.
- Splits input x into a table index x1 (upper bits) and an offset x2 (lower bits), fetches {a,b,c} from a synchronous coefficient ROM, drives quadra, and registers the result.
- Valid/ready on input and output, with full backpressure.
- Sits between the sample source and the downstream consumer; the ROM is external.

---
 rtl/quadra_pkg.sv | 36 +++
 rtl/quadra.sv | 35 +++
 rtl/quadra_ctrl.sv | 160 ++++++++++++++++
 3 files changed

// File: rtl/quadra_pkg.sv
`default_nettype none
// =============================================================================
// quadra_pkg: shared widths, coefficient types and offset helper for quadra.
// Rev 1.0
// =============================================================================
package quadra_pkg;

  localparam int X2_BITS = 10;
  localparam int A_W     = 16;
  localparam int B_W     = 16;
  localparam int C_W     = 16;
  localparam int SQ_W    = 2 * X2_BITS;
  localparam int Y_AB    = (A_W > B_W + X2_BITS) ? A_W : (B_W + X2_BITS);
  localparam int Y_W     = ((Y_AB > C_W + SQ_W) ? Y_AB : (C_W + SQ_W)) + 2;
  localparam int COEF_W  = A_W + B_W + C_W;

  typedef logic signed [X2_BITS-1:0] x2_t;
  typedef logic signed [A_W-1:0]     a_t;
  typedef logic signed [B_W-1:0]     b_t;
  typedef logic signed [C_W-1:0]     c_t;
  typedef logic signed [SQ_W-1:0]    sq_t;
  typedef logic signed [Y_W-1:0]     y_t;

  typedef struct packed {
    a_t a;
    b_t b;
    c_t c;
  } coef_t;

  // Inverting the offset MSB centres the segment around zero.
  function automatic x2_t centre_offset(input logic [X2_BITS-1:0] off);
    return $signed({~off[X2_BITS-1], off[X2_BITS-2:0]});
  endfunction

endpackage
`default_nettype wire

// File: rtl/quadra.sv
`default_nettype none
// =============================================================================
// quadra: combinational datapath y = a + b*x2 + c*x2^2 at full precision.
// Rev 1.0
// =============================================================================
module quadra
  import quadra_pkg::*;
(
  input  logic [A_W-1:0]     a_i,
  input  logic [B_W-1:0]     b_i,
  input  logic [C_W-1:0]     c_i,
  input  logic [X2_BITS-1:0] x2_i,
  output logic [Y_W-1:0]     y_o
);

  x2_t x2;
  sq_t sq;
  y_t  t_a;
  y_t  t_b;
  y_t  t_c;

  always_comb begin : p_square
    x2 = $signed(x2_i);
    sq = sq_t'(x2) * sq_t'(x2);
  end

  always_comb begin : p_poly
    t_a = y_t'($signed(a_i));
    t_b = y_t'($signed(b_i)) * y_t'(x2);
    t_c = y_t'($signed(c_i)) * y_t'(sq);
    y_o = t_a + t_b + t_c;
  end

endmodule
`default_nettype wire

// File: rtl/quadra_ctrl.sv
`default_nettype none
// =============================================================================
// quadra_ctrl: two-stage valid/ready sequencer around quadra with ROM fetch.
// Optional QUADRA_CTRL_SAT_EN: saturating narrowing plus sticky sat_flag.
// Rev 1.0
// =============================================================================
module quadra_ctrl
  import quadra_pkg::*;
#(
  parameter int X_W        = 16,
  parameter int X1_W       = 6,
  parameter int X2_W       = X_W - X1_W,
  parameter int OUT_W      = 16,
  parameter int FRAC_SHIFT = 0
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              flush,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [X_W-1:0]    in_x,
  output logic              coef_rd_en,
  output logic [X1_W-1:0]   coef_addr,
  input  logic [COEF_W-1:0] coef_data,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [OUT_W-1:0]  out_y,
  output logic              busy,
  output logic [15:0]       sample_cnt
`ifdef QUADRA_CTRL_SAT_EN
  ,
  output logic              sat_flag
`endif
);

  logic             v1_q, v1_d;
  x2_t              x2_q, x2_d;
  logic             out_valid_q, out_valid_d;
  logic [OUT_W-1:0] out_y_q, out_y_d;
  logic [15:0]      cnt_q, cnt_d;

  logic             adv1, adv2, accept;
  x2_t              x2_in;
  coef_t            coef;
  logic [Y_W-1:0]   y_full;
  y_t               y_sh;
  logic [OUT_W-1:0] narrow;

  assign adv2     = !out_valid_q || out_ready;
  assign adv1     = adv2 || !v1_q;
  assign in_ready = adv1 && !flush;
  assign accept   = in_valid && in_ready;

  assign coef_rd_en = accept;
  assign coef_addr  = in_x[X_W-1:X2_W];
  assign x2_in      = centre_offset(in_x[X2_W-1:0]);
  assign coef       = coef_t'(coef_data);

  quadra u_quadra (
    .a_i  (coef.a),
    .b_i  (coef.b),
    .c_i  (coef.c),
    .x2_i (x2_q),
    .y_o  (y_full)
  );

  assign y_sh = $signed(y_full) >>> FRAC_SHIFT;

`ifdef QUADRA_CTRL_SAT_EN
  localparam y_t Y_MAX = {{(Y_W-OUT_W+1){1'b0}}, {(OUT_W-1){1'b1}}};
  localparam y_t Y_MIN = {{(Y_W-OUT_W+1){1'b1}}, {(OUT_W-1){1'b0}}};

  logic sat_q, sat_d;
  logic sat_hit;

  always_comb begin
    sat_hit = 1'b0;
    narrow  = OUT_W'(y_sh);
    if (y_sh > Y_MAX) begin
      sat_hit = 1'b1;
      narrow  = {1'b0, {(OUT_W-1){1'b1}}};
    end else if (y_sh < Y_MIN) begin
      sat_hit = 1'b1;
      narrow  = {1'b1, {(OUT_W-1){1'b0}}};
    end
  end

  assign sat_flag = sat_q;
`else
  assign narrow = OUT_W'(y_sh);
`endif

  always_comb begin
    v1_d        = v1_q;
    x2_d        = x2_q;
    out_valid_d = out_valid_q;
    out_y_d     = out_y_q;
    cnt_d       = cnt_q;
`ifdef QUADRA_CTRL_SAT_EN
    sat_d       = sat_q;
`endif

    if (accept) begin
      v1_d = 1'b1;
      x2_d = x2_in;
    end else if (adv2) begin
      v1_d = 1'b0;
    end

    // Output stage refills from stage 1 or empties after a handshake.
    if (adv2) begin
      out_valid_d = v1_q;
      if (v1_q) begin
        out_y_d = narrow;
`ifdef QUADRA_CTRL_SAT_EN
        if (sat_hit) sat_d = 1'b1;
`endif
      end
    end

    if (out_valid_q && out_ready) cnt_d = cnt_q + 16'd1;

    if (flush) begin
      v1_d        = 1'b0;
      out_valid_d = 1'b0;
`ifdef QUADRA_CTRL_SAT_EN
      sat_d       = 1'b0;
`endif
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      v1_q        <= 1'b0;
      x2_q        <= '0;
      out_valid_q <= 1'b0;
      out_y_q     <= '0;
      cnt_q       <= '0;
`ifdef QUADRA_CTRL_SAT_EN
      sat_q       <= 1'b0;
`endif
    end else begin
      v1_q        <= v1_d;
      x2_q        <= x2_d;
      out_valid_q <= out_valid_d;
      out_y_q     <= out_y_d;
      cnt_q       <= cnt_d;
`ifdef QUADRA_CTRL_SAT_EN
      sat_q       <= sat_d;
`endif
    end
  end

  assign out_valid  = out_valid_q;
  assign out_y      = out_y_q;
  assign busy       = v1_q || out_valid_q;
  assign sample_cnt = cnt_q;

endmodule
`default_nettype wire
